// File: rtl/biriscv_trace_buffer.sv
// Retire-trace capture buffer for biRISC-V: circular capture, PC-match trigger freeze, oldest-first drain.
// Optional per-entry cycle timestamps are enabled by defining BIRISCV_TRACE_TS_EN.
module biriscv_trace_buffer #(
  parameter int LANES     = 2,
  parameter int DEPTH     = 64,
  parameter int DEPTH_W   = 6,
  parameter int SEQ_W     = 16,
  parameter int POST_TRIG = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [LANES-1:0]     valid_i,
  input  logic [32*LANES-1:0]  pc_i,
  input  logic [32*LANES-1:0]  opcode_i,
  input  logic                 arm_i,
  input  logic                 abort_i,
  input  logic                 trig_en_i,
  input  logic [31:0]          trig_pc_i,
  output logic                 rd_valid_o,
  input  logic                 rd_ready_i,
  output logic [31:0]          rd_pc_o,
  output logic [31:0]          rd_opcode_o,
  output logic [SEQ_W-1:0]     rd_seq_o,
  output logic [31:0]          rd_ts_o,
  output logic [1:0]           state_o,
  output logic [DEPTH_W:0]     count_o,
  output logic                 wrapped_o
);

  localparam int CNT_W = DEPTH_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_POST    = 2'd2,
    ST_READOUT = 2'd3
  } state_t;

  state_t               state_r;
  logic [DEPTH_W-1:0]   wr_ptr_r;
  logic [DEPTH_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]     count_r;
  logic [SEQ_W-1:0]     seq_r;
  logic [CNT_W-1:0]     post_cnt_r;
  logic                 wrapped_r;

  logic [31:0]          pc_mem_r  [DEPTH];
  logic [31:0]          op_mem_r  [DEPTH];
  logic [SEQ_W-1:0]     seq_mem_r [DEPTH];

  logic [CNT_W-1:0]     n_s;
  logic [CNT_W-1:0]     off_s  [LANES];
  logic [DEPTH_W-1:0]   slot_s [LANES];
  logic                 trig_hit_s;
  logic                 capture_s;
  logic [CNT_W:0]       sum_s;
  logic                 overflow_s;
  logic [CNT_W-1:0]     count_nxt_s;
  logic [DEPTH_W-1:0]   wr_nxt_s;
  logic                 post_done_s;

  // Per-lane slot offsets: valid lanes pack into consecutive slots in lane order.
  always_comb begin
    n_s        = '0;
    trig_hit_s = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      off_s[l]  = n_s;
      slot_s[l] = wr_ptr_r + n_s[DEPTH_W-1:0];
      if (valid_i[l]) begin
        if (trig_en_i && (pc_i[32*l +: 32] == trig_pc_i)) begin
          trig_hit_s = 1'b1;
        end else begin
          trig_hit_s = trig_hit_s;
        end
        n_s = n_s + CNT_W'(1);
      end else begin
        n_s = n_s;
      end
    end
  end

  // Occupancy and pointer arithmetic for this cycle's capture.
  always_comb begin
    capture_s   = (state_r == ST_ARMED) || (state_r == ST_POST);
    sum_s       = {1'b0, count_r} + {1'b0, n_s};
    overflow_s  = (sum_s > (CNT_W+1)'(DEPTH));
    if (overflow_s) begin
      count_nxt_s = CNT_W'(DEPTH);
    end else begin
      count_nxt_s = sum_s[CNT_W-1:0];
    end
    wr_nxt_s    = wr_ptr_r + n_s[DEPTH_W-1:0];
    post_done_s = (n_s != '0) && (post_cnt_r <= n_s);
  end

  // Entry storage; content is only meaningful within the count window.
  always_ff @(posedge clk_i) begin
    for (int l = 0; l < LANES; l++) begin
      if (capture_s && valid_i[l]) begin
        pc_mem_r[slot_s[l]]  <= pc_i[32*l +: 32];
        op_mem_r[slot_s[l]]  <= opcode_i[32*l +: 32];
        seq_mem_r[slot_s[l]] <= seq_r + SEQ_W'(off_s[l]);
      end
    end
  end

  // Capture/trigger/drain control.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= ST_IDLE;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      seq_r      <= '0;
      post_cnt_r <= '0;
      wrapped_r  <= 1'b0;
    end else if (abort_i) begin
      state_r    <= ST_IDLE;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      post_cnt_r <= '0;
      wrapped_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (arm_i) begin
            state_r    <= ST_ARMED;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            seq_r      <= '0;
            post_cnt_r <= '0;
            wrapped_r  <= 1'b0;
          end
        end
        ST_ARMED, ST_POST: begin
          wr_ptr_r <= wr_nxt_s;
          count_r  <= count_nxt_s;
          // Oldest entry sits count slots behind the write pointer.
          rd_ptr_r <= wr_nxt_s - count_nxt_s[DEPTH_W-1:0];
          seq_r    <= seq_r + SEQ_W'(n_s);
          if (overflow_s) begin
            wrapped_r <= 1'b1;
          end
          if (state_r == ST_ARMED) begin
            if (trig_hit_s) begin
              post_cnt_r <= CNT_W'(POST_TRIG);
              state_r    <= (POST_TRIG == 0) ? ST_READOUT : ST_POST;
            end
          end else begin
            if (post_done_s) begin
              post_cnt_r <= '0;
              state_r    <= ST_READOUT;
            end else begin
              post_cnt_r <= post_cnt_r - n_s;
            end
          end
        end
        ST_READOUT: begin
          if (count_r == '0) begin
            state_r <= ST_IDLE;
          end else if (rd_ready_i) begin
            rd_ptr_r <= rd_ptr_r + DEPTH_W'(1);
            count_r  <= count_r - CNT_W'(1);
            if (count_r == CNT_W'(1)) begin
              state_r <= ST_IDLE;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef BIRISCV_TRACE_TS_EN
  logic [31:0] cycle_r;
  logic [31:0] ts_mem_r [DEPTH];

  // Free-running cycle counter, stamped into each captured entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycle_r <= '0;
    end else begin
      cycle_r <= cycle_r + 32'd1;
    end
    for (int l = 0; l < LANES; l++) begin
      if (capture_s && valid_i[l]) begin
        ts_mem_r[slot_s[l]] <= cycle_r;
      end
    end
  end

  assign rd_ts_o = ts_mem_r[rd_ptr_r];
`else
  assign rd_ts_o = 32'd0;
`endif

  assign rd_valid_o  = (state_r == ST_READOUT) && (count_r != '0);
  assign rd_pc_o     = pc_mem_r[rd_ptr_r];
  assign rd_opcode_o = op_mem_r[rd_ptr_r];
  assign rd_seq_o    = seq_mem_r[rd_ptr_r];
  assign state_o     = state_r;
  assign count_o     = count_r;
  assign wrapped_o   = wrapped_r;

endmodule

// File: tb/tb_biriscv_trace_buffer.sv
// Scoreboard bench for biriscv_trace_buffer: dut_a uses POST_TRIG=8, dut_b POST_TRIG=0, shared stimulus.
module tb_biriscv_trace_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  valid;
  logic [63:0] pc;
  logic [63:0] opcode;
  logic        arm;
  logic        abort;
  logic        trig_en;
  logic [31:0] trig_pc;
  logic        rd_ready;

  logic        a_rd_valid, b_rd_valid;
  logic [31:0] a_rd_pc, b_rd_pc, a_rd_opcode, b_rd_opcode, a_rd_ts, b_rd_ts;
  logic [15:0] a_rd_seq, b_rd_seq;
  logic [1:0]  a_state, b_state;
  logic [6:0]  a_count, b_count;
  logic        a_wrapped, b_wrapped;

  always #5 clk = ~clk;

  biriscv_trace_buffer #(.LANES(2), .DEPTH(64), .DEPTH_W(6), .SEQ_W(16), .POST_TRIG(8)) dut_a (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .pc_i(pc), .opcode_i(opcode),
    .arm_i(arm), .abort_i(abort), .trig_en_i(trig_en), .trig_pc_i(trig_pc),
    .rd_valid_o(a_rd_valid), .rd_ready_i(rd_ready), .rd_pc_o(a_rd_pc),
    .rd_opcode_o(a_rd_opcode), .rd_seq_o(a_rd_seq), .rd_ts_o(a_rd_ts),
    .state_o(a_state), .count_o(a_count), .wrapped_o(a_wrapped));

  biriscv_trace_buffer #(.LANES(2), .DEPTH(64), .DEPTH_W(6), .SEQ_W(16), .POST_TRIG(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .pc_i(pc), .opcode_i(opcode),
    .arm_i(arm), .abort_i(abort), .trig_en_i(trig_en), .trig_pc_i(trig_pc),
    .rd_valid_o(b_rd_valid), .rd_ready_i(rd_ready), .rd_pc_o(b_rd_pc),
    .rd_opcode_o(b_rd_opcode), .rd_seq_o(b_rd_seq), .rd_ts_o(b_rd_ts),
    .state_o(b_state), .count_o(b_count), .wrapped_o(b_wrapped));

  logic        sel_b;
  logic        m_valid;
  logic [31:0] m_pc, m_op, m_ts;
  logic [15:0] m_seq;
  logic [1:0]  m_state;
  assign m_valid = sel_b ? b_rd_valid  : a_rd_valid;
  assign m_pc    = sel_b ? b_rd_pc     : a_rd_pc;
  assign m_op    = sel_b ? b_rd_opcode : a_rd_opcode;
  assign m_seq   = sel_b ? b_rd_seq    : a_rd_seq;
  assign m_ts    = sel_b ? b_rd_ts     : a_rd_ts;
  assign m_state = sel_b ? b_state     : a_state;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] op;
    logic [15:0] seq;
  } ent_t;

  ent_t        sb[$];
  logic [15:0] mseq;
  bit          cap;
  logic [31:0] last_pc;
  int          checks = 0;
  int          errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] op_of(input logic [31:0] p);
    return p ^ 32'h00A5_5A13;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one retire cycle; the model records what a capturing buffer must keep.
  task automatic retire(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1);
    ent_t e;
    valid  = v;
    pc     = {p1, p0};
    opcode = {op_of(p1), op_of(p0)};
    if (cap) begin
      for (int l = 0; l < 2; l++) begin
        if (v[l]) begin
          e.pc  = (l == 0) ? p0 : p1;
          e.op  = op_of(e.pc);
          e.seq = mseq;
          mseq  = mseq + 16'd1;
          sb.push_back(e);
          if (sb.size() > 64) void'(sb.pop_front());
        end
      end
    end
    step();
    valid = 2'b00;
  endtask

  task automatic drain(input bit use_b, input bit toggle, input int ts_step);
    int          n;
    int          phase;
    bit          have_ts;
    logic [31:0] prev_ts;
    sel_b   = use_b;
    n       = sb.size();
    phase   = 0;
    have_ts = 1'b0;
    prev_ts = 32'd0;
    #0;
    for (int guard = 0; guard < 4 * n + 8 && sb.size() > 0; guard++) begin
      check_eq("rd_valid", 64'(m_valid), 64'd1);
      check_eq("rd_pc", 64'(m_pc), 64'(sb[0].pc));
      check_eq("rd_opcode", 64'(m_op), 64'(sb[0].op));
      check_eq("rd_seq", 64'(m_seq), 64'(sb[0].seq));
      if (toggle && !phase[0]) begin
        rd_ready = 1'b0;
        step();
      end else begin
`ifdef BIRISCV_TRACE_TS_EN
        if (have_ts && ts_step != 0) check_eq("rd_ts_delta", 64'(m_ts - prev_ts), 64'(ts_step));
        prev_ts = m_ts;
        have_ts = 1'b1;
`else
        check_eq("rd_ts_zero", 64'(m_ts), 64'd0);
`endif
        last_pc  = sb[0].pc;
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        void'(sb.pop_front());
      end
      phase++;
    end
    check_eq("drain_left", 64'(sb.size()), 64'd0);
    check_eq("idle_after_drain", 64'(m_state), 64'd0);
    check_eq("rd_valid_after", 64'(m_valid), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 2'b00; pc = 64'd0; opcode = 64'd0; arm = 1'b0; abort = 1'b0;
    trig_en = 1'b0; trig_pc = 32'd0; rd_ready = 1'b0;
    cap = 1'b0; mseq = 16'd0; sb.delete();
    step(); step();
    rst = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
    cap = 1'b1;
    mseq = 16'd0;
    sb.delete();
  endtask

  initial begin
    sel_b = 1'b0;
    last_pc = 32'd0;
    do_reset();
    check_eq("rst_state", 64'(a_state), 64'd0);
    check_eq("rst_count", 64'(a_count), 64'd0);
    check_eq("rst_wrapped", 64'(a_wrapped), 64'd0);
    check_eq("rst_rd_valid", 64'(a_rd_valid), 64'd0);
    retire(2'b11, 32'h8000_0000, 32'h8000_0004);
    check_eq("idle_ignores_valid", 64'(a_count), 64'd0);

    // Capture ten entries, then abort.
    do_arm();
    check_eq("armed_state", 64'(a_state), 64'd1);
    for (int k = 0; k < 5; k++) retire(2'b11, 32'h8000_0000 + 32'(8 * k), 32'h8000_0004 + 32'(8 * k));
    check_eq("count_10", 64'(a_count), 64'd10);
    check_eq("no_wrap_10", 64'(a_wrapped), 64'd0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("abort_state", 64'(a_state), 64'd0);
    check_eq("abort_count", 64'(a_count), 64'd0);

    // Wrap, trigger on lane 1, four post cycles, toggled drain.
    do_reset();
    do_arm();
    trig_en = 1'b1;
    trig_pc = 32'h8000_0144;
    for (int k = 0; k < 40; k++) retire(2'b11, 32'h8000_0000 + 32'(8 * k), 32'h8000_0004 + 32'(8 * k));
    retire(2'b11, 32'h8000_0140, 32'h8000_0144);
    check_eq("post_state", 64'(a_state), 64'd2);
    for (int k = 0; k < 3; k++) retire(2'b11, 32'h8000_0148 + 32'(8 * k), 32'h8000_014C + 32'(8 * k));
    check_eq("still_post", 64'(a_state), 64'd2);
    retire(2'b11, 32'h8000_0160, 32'h8000_0164);
    check_eq("readout_state", 64'(a_state), 64'd3);
    check_eq("wrapped", 64'(a_wrapped), 64'd1);
    check_eq("count_full", 64'(a_count), 64'd64);
    cap = 1'b0;
    retire(2'b11, 32'hDEAD_0000, 32'hDEAD_0004);
    check_eq("frozen_count", 64'(a_count), 64'd64);
    drain(1'b0, 1'b1, 0);
    check_eq("last_pc", 64'(last_pc), 64'h8000_0164);

    // Lane-1-only retire, then POST_TRIG=0 trigger on the 3rd instruction.
    do_reset();
    do_arm();
    trig_en = 1'b1;
    trig_pc = 32'h0000_0108;
    retire(2'b10, 32'h0000_0000, 32'h0000_0100);
    check_eq("lane1_only_count", 64'(a_count), 64'd1);
    retire(2'b11, 32'h0000_0104, 32'h0000_0108);
    check_eq("b_readout", 64'(b_state), 64'd3);
    check_eq("b_count", 64'(b_count), 64'd3);
    check_eq("a_post", 64'(a_state), 64'd2);
    cap = 1'b0;
    drain(1'b1, 1'b0, 0);

    // Single-lane retire every third cycle, timestamp spacing.
    do_reset();
    do_arm();
    trig_en = 1'b1;
    trig_pc = 32'h0000_020C;
    for (int i = 0; i < 4; i++) begin
      retire(2'b01, 32'h0000_0200 + 32'(4 * i), 32'd0);
      if (i < 3) begin
        step();
        step();
      end
    end
    cap = 1'b0;
    check_eq("ts_b_readout", 64'(b_state), 64'd3);
    drain(1'b1, 1'b0, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
